// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, one quotient bit per clock.
// Divides an unsigned DW-bit dividend by an unsigned VW-bit divisor and
// presents a DW-bit quotient and VW-bit remainder behind a start/busy/done
// handshake. With default widths it undoes the 3x3 array multiplier.
module seq_divider #(
  parameter int DW = 6,
  parameter int VW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] inA,
  input  logic [VW-1:0] inB,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] outQ,
  output logic [VW-1:0] outR,
  output logic          div_zero
);

  localparam int CW = $clog2(DW + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [DW-1:0] q;          // dividend shifting out, quotient shifting in
  logic [VW-1:0] d;          // captured divisor
  logic [VW:0]   p;          // partial remainder
  logic [CW-1:0] cnt;        // remaining iterations

  logic [VW+1:0] t;          // shifted partial remainder with next dividend bit
  logic [VW+1:0] t_sub;
  logic          ge;
  logic [VW:0]   p_next;
  logic [DW-1:0] q_next;
  logic          accept;

  // A new operation is accepted only from IDLE or DONE; CALC ignores start.
  assign accept = start && ((state == IDLE) || (state == DONE));

  assign busy = (state == CALC);
  assign done = (state == DONE);

  // One restoring step: shift in the next dividend bit, trial-subtract the
  // divisor and keep the difference only when it did not go negative.
  // p stays below d after every step, so its top bit is always zero; it is
  // carried through the compare anyway so the step is exact as written.
  always_comb begin
    t      = {p, q[DW-1]};
    ge     = (t >= {2'b00, d});
    t_sub  = t - {2'b00, d};
    p_next = ge ? t_sub[VW:0] : t[VW:0];
    q_next = {q[DW-2:0], ge};
  end

  // Control FSM plus datapath registers; results update only on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      q        <= '0;
      d        <= '0;
      p        <= '0;
      cnt      <= '0;
      outQ     <= '0;
      outR     <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            q        <= inA;
            d        <= inB;
            p        <= '0;
            cnt      <= CW'(DW);
            div_zero <= 1'b0;
            if (inB == '0) begin
              // Divide by zero: skip iteration, report saturated quotient.
              state    <= DONE;
              outQ     <= '1;
              outR     <= '0;
              div_zero <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          q   <= q_next;
          p   <= p_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= DONE;
            outQ  <= q_next;
            outR  <= p_next[VW-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and sweep checks of seq_divider at default widths.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [5:0] inA = '0;
  logic [2:0] inB = '0;
  logic       busy, done, div_zero;
  logic [5:0] outQ;
  logic [2:0] outR;

  int n_vec  = 0;
  int n_miss = 0;

  logic [5:0] prev_q;
  logic [2:0] prev_r;

  seq_divider #(.DW(6), .VW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .inA(inA), .inB(inB),
    .busy(busy), .done(done), .outQ(outQ), .outR(outR), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive a start at the negedge; return 1ns after the accept edge (sample 0).
  task automatic start_op(input int a, input int b);
    @(negedge clk);
    prev_q = outQ;
    prev_r = outR;
    start = 1'b1;
    inA = 6'(a);
    inB = 3'(b);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for done; lat counts edges after the accept edge.
  task automatic wait_done(input int inject_at, output int lat, output int bcnt,
                           output bit held, output bit overlap);
    lat = 0; bcnt = 0; held = 1'b1; overlap = 1'b0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      if (busy && done) overlap = 1'b1;
      if (outQ !== prev_q || outR !== prev_r) held = 1'b0;
      if (lat == inject_at) begin
        start = 1'b1; inA = 6'd10; inB = 3'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    if (busy && done) overlap = 1'b1;
  endtask

  task automatic run_op(input string tag, input int a, input int b, input int inject_at,
                        input int eq, input int er, input int ez, input int elat);
    int lat, bcnt;
    bit held, overlap;
    start_op(a, b);
    wait_done(inject_at, lat, bcnt, held, overlap);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_busy_cycles"}, bcnt, elat);
    check({tag, "_q"}, outQ, eq);
    check({tag, "_r"}, outR, er);
    check({tag, "_dz"}, div_zero, ez);
    check({tag, "_held"}, held, 1);
    check({tag, "_overlap"}, overlap, 0);
  endtask

  initial begin
    int lat, bcnt;
    bit held, overlap;

    // Reset state
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", outQ, 0);
    check("rst_r", outR, 0);
    check("rst_dz", div_zero, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op("d45_6", 45, 6, -1, 7, 3, 0, 6);
    run_op("d63_7", 63, 7, -1, 9, 0, 0, 6);

    // Back-to-back: start issued in the DONE cycle, done must fall at once.
    start_op(5, 7);
    check("b2b_done_drop", done, 0);
    check("b2b_busy", busy, 1);
    wait_done(-1, lat, bcnt, held, overlap);
    check("d5_7_lat", lat, 6);
    check("d5_7_q", outQ, 0);
    check("d5_7_r", outR, 5);
    check("d5_7_held", held, 1);

    // Divide by zero: DONE right after the accept edge.
    run_op("d42_0", 42, 0, -1, 63, 0, 1, 0);
    run_op("d42_1", 42, 1, -1, 42, 0, 0, 6);

    // Start pulsed during CALC cycle 3 is ignored.
    run_op("ign45_6", 45, 6, 3, 7, 3, 0, 6);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("ign_done_hold", done, 1);
    check("ign_q_hold", outQ, 7);

    // Asynchronous reset mid-CALC.
    start_op(60, 5);
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("mid_busy_before_rst", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_q", outQ, 0);
    check("arst_r", outR, 0);
    check("arst_dz", div_zero, 0);
    #1 rst = 1'b0;
    lat = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) lat++;
    end
    check("arst_no_done", lat, 0);
    run_op("d60_5", 60, 5, -1, 12, 0, 0, 6);

    // Sweep all nonzero-divisor pairs with random idle gaps.
    for (int a = 0; a < 64; a++) begin
      for (int b = 1; b < 8; b++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        start_op(a, b);
        wait_done(-1, lat, bcnt, held, overlap);
        check($sformatf("sw%0d_%0d_lat", a, b), lat, 6);
        check($sformatf("sw%0d_%0d_q", a, b), outQ, a / b);
        check($sformatf("sw%0d_%0d_r", a, b), outR, a % b);
        check($sformatf("sw%0d_%0d_id", a, b),
              (int'(outQ) * b + int'(outR) == a) && (int'(outR) < b), 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
